// File: rtl/serial_pkg.sv
// Shared serial framing definitions: FSM state encoding and counter width helper.
// Used by the RX framer and intended for the matching TX framer.
package serial_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } serial_state_t;

    // Width needed to count 0..n-1, never below 1 bit.
    function automatic int bit_cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input, synchronous active-low reset to 0.
// Latency 2 clk; no backpressure.
module serial_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/serial_rx_framer.sv
// Oversampled async serial receiver: start validation, LSB-first data, optional parity (SERIAL_RX_PARITY_EN), stop check.
// Stop sample OVERSAMPLE/2 + OVERSAMPLE*(DATA_BITS+1[+1]) ce-ticks after start detect; no backpressure.
module serial_rx_framer #(
    parameter int OVERSAMPLE  = 16,
    parameter int DATA_BITS   = 8,
    parameter int START_LEVEL = 1,
    parameter int PARITY_ODD  = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce,
    input  logic                 din,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 bit_en,
    output logic                 busy
);

    import serial_pkg::*;

    localparam int CNT_W  = bit_cnt_w(OVERSAMPLE);
    localparam int BITN_W = bit_cnt_w(DATA_BITS);
    localparam logic [CNT_W-1:0]  CNT_MID   = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BITN_W-1:0] BITN_LAST = BITN_W'(DATA_BITS - 1);
    localparam logic START_LVL = (START_LEVEL != 0);
    localparam logic PAR_ODD   = (PARITY_ODD != 0);
`ifdef SERIAL_RX_PARITY_EN
    localparam logic PAR_EN = 1'b1;
`else
    localparam logic PAR_EN = 1'b0;
`endif

    serial_state_t          state;
    logic [CNT_W-1:0]       cnt;
    logic [BITN_W-1:0]      bitn;
    logic [DATA_BITS-1:0]   shift;
    logic                   par_bit;
    logic                   ds;
    logic                   par_bad;

    serial_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (din),
        .q   (ds)
    );

    assign par_bad = PAR_EN && ((^shift ^ PAR_ODD) != par_bit);
    assign busy    = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            bitn       <= '0;
            shift      <= '0;
            par_bit    <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            bit_en     <= 1'b0;
        end else begin
            // Strobes last exactly one clk, independent of ce.
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            bit_en     <= 1'b0;
            if (ce) begin
                case (state)
                    ST_IDLE: begin
                        if (ds == START_LVL) begin
                            state <= ST_START;
                            cnt   <= '0;
                        end
                    end
                    ST_START: begin
                        if (cnt == CNT_MID) begin
                            cnt <= '0;
                            if (ds == START_LVL) begin
                                bit_en <= 1'b1;
                                bitn   <= '0;
                                state  <= ST_DATA;
                            end else begin
                                state  <= ST_IDLE;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ST_DATA: begin
                        if (cnt == CNT_LAST) begin
                            cnt    <= '0;
                            bit_en <= 1'b1;
                            shift  <= {ds, shift[DATA_BITS-1:1]};
                            if (bitn == BITN_LAST)
                                state <= PAR_EN ? ST_PARITY : ST_STOP;
                            else
                                bitn <= bitn + 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ST_PARITY: begin
                        if (cnt == CNT_LAST) begin
                            cnt     <= '0;
                            bit_en  <= 1'b1;
                            par_bit <= ds;
                            state   <= ST_STOP;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ST_STOP: begin
                        if (cnt == CNT_LAST) begin
                            cnt        <= '0;
                            bit_en     <= 1'b1;
                            rx_data    <= shift;
                            parity_err <= par_bad;
                            if (ds != START_LVL) begin
                                rx_valid <= !par_bad;
                                state    <= ST_IDLE;
                            end else begin
                                // Framing error wins over rx_valid; wait for idle so a break cannot retrigger.
                                frame_err <= 1'b1;
                                state     <= ST_WAIT_IDLE;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ST_WAIT_IDLE: begin
                        if (ds != START_LVL)
                            state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
